// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the multi-channel countdown timer:
//   - CNT_W_DEFAULT : default width of each channel counter (200 s at 1 ms)
//   - ch_state_e    : per-channel state encoding (IDLE / RUN)
//   - calc_div      : system-clock cycles per tick, CLK_HZ / TICK_HZ
// No ports; imported by timer_prescaler and multi_channel_timer.
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int CNT_W_DEFAULT = 18;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // Prescaler division ratio; the caller guarantees an integer result >= 2.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Free-running divider producing a registered one-cycle tick every
// CLK_HZ/TICK_HZ system clocks.
// Ports:
//   clk   in  system clock (posedge)
//   reset in  synchronous, active-high; clears divider and tick
//   tick  out one-cycle pulse, once per division period
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 10000,
    parameter int TICK_HZ = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV  = calc_div(CLK_HZ, TICK_HZ);
    localparam int DW   = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          tick_q, tick_d;

    // Divider wraps at DIV-1; the wrap cycle is what raises the tick,
    // which appears on the output one clock later because it is registered.
    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        tick_d    = 1'b0;
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end
    end

    // Divider and tick registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_channel_timer.sv
// -----------------------------------------------------------------------------
// multi_channel_timer
// N_CH independent countdown channels sharing one tick prescaler. Each
// channel loads a tick count on start, decrements on every tick while
// running, and pulses expired for one cycle when it times out. With
// auto_reload set at expiry the channel reloads load_value and keeps going.
// Ports:
//   clk         in  system clock (posedge)
//   reset       in  synchronous, active-high
//   start       in  [N_CH]        load load_value[ch] and run (restarts too)
//   stop        in  [N_CH]        pause, count held
//   auto_reload in  [N_CH]        1 = periodic, 0 = one-shot
//   load_value  in  [N_CH*CNT_W]  channel ch at [ch*CNT_W +: CNT_W]
//   tick        out               prescaler pulse
//   running     out [N_CH]        channel is counting
//   expired     out [N_CH]        one-cycle timeout pulse
//   count_out   out [N_CH*CNT_W]  remaining ticks, packed like load_value
// -----------------------------------------------------------------------------
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 10000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       stop,
    input  logic [N_CH-1:0]       auto_reload,
    input  logic [N_CH*CNT_W-1:0] load_value,
    output logic                  tick,
    output logic [N_CH-1:0]       running,
    output logic [N_CH-1:0]       expired,
    output logic [N_CH*CNT_W-1:0] count_out
);

    logic tick_w;

    timer_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_w)
    );

    assign tick = tick_w;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic             expired_q, expired_d;
        logic [CNT_W-1:0] load_w;

        assign load_w = load_value[ch*CNT_W +: CNT_W];

        // Channel next state. Priority is start > stop > tick. A zero load
        // on start is treated as an immediate timeout. At the final tick the
        // channel either reloads (periodic, non-zero load) or parks in IDLE
        // with a zero count; a start on that same cycle wins, so no pulse.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            expired_d = 1'b0;
            if (start[ch]) begin
                if (load_w != '0) begin
                    count_d = load_w;
                    state_d = ST_RUN;
                end else begin
                    count_d   = '0;
                    state_d   = ST_IDLE;
                    expired_d = 1'b1;
                end
            end else if (stop[ch]) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_RUN && tick_w) begin
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    expired_d = 1'b1;
                    if (auto_reload[ch] && load_w != '0) begin
                        count_d = load_w;
                        state_d = ST_RUN;
                    end else begin
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
        end

        // Channel state, count and expiry pulse registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= ST_IDLE;
                count_q   <= '0;
                expired_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                expired_q <= expired_d;
            end
        end

        assign running[ch]                   = (state_q == ST_RUN);
        assign expired[ch]                   = expired_q;
        assign count_out[ch*CNT_W +: CNT_W]  = count_q;
    end

endmodule

// File: tb/tb_multi_channel_timer.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_timer
// Directed scenarios followed by a randomized phase, checked every cycle
// against a behavioural reference model of the timer kept in integers.
// -----------------------------------------------------------------------------
module tb_multi_channel_timer;

    localparam int CLK_HZ  = 10000;
    localparam int TICK_HZ = 1000;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int N_CH    = 4;
    localparam int CNT_W   = 18;
    localparam int VW      = N_CH * CNT_W;

    logic                  clk;
    logic                  reset;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       auto_reload;
    logic [VW-1:0]         load_value;
    logic                  tick;
    logic [N_CH-1:0]       running;
    logic [N_CH-1:0]       expired;
    logic [VW-1:0]         count_out;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: cycles since reset release, per-channel remaining
    // ticks, running flag and pending expiry pulse.
    int sinceReset = 0;
    int mCnt[N_CH];
    bit mRun[N_CH];
    bit mExp[N_CH];

    // Observed expiry edges per channel, used for the timing checks.
    int expQ[N_CH][$];

    multi_channel_timer #(
        .CLK_HZ      (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .N_CH        (N_CH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .load_value  (load_value),
        .tick        (tick),
        .running     (running),
        .expired     (expired),
        .count_out   (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkVal(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The tick is high during the cycles after every DIV-th clock since
    // reset release.
    function automatic bit tickAt(input int n);
        return (n > 0) && (n % DIV == 0);
    endfunction

    function automatic int loadOf(input int ch);
        return int'(load_value[ch*CNT_W +: CNT_W]);
    endfunction

    // Compare every DUT output against the reference model.
    task automatic checkOutput();
        logic [VW-1:0] eRun, eExp, eCnt;
        eRun = '0;
        eExp = '0;
        eCnt = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            eRun[ch] = mRun[ch];
            eExp[ch] = mExp[ch];
            eCnt[ch*CNT_W +: CNT_W] = CNT_W'(mCnt[ch]);
        end
        checkVal("tick",      VW'(tick),    VW'(tickAt(sinceReset)));
        checkVal("running",   VW'(running), eRun);
        checkVal("expired",   VW'(expired), eExp);
        checkVal("count_out", count_out,    eCnt);
    endtask

    // Advance one clock: the model takes the inputs present at the edge,
    // then outputs are compared shortly after the edge.
    task automatic runCycle();
        bit tk;
        int lv;
        tk = tickAt(sinceReset);
        @(posedge clk);
        if (reset) begin
            sinceReset = 0;
            for (int ch = 0; ch < N_CH; ch++) begin
                mCnt[ch] = 0;
                mRun[ch] = 0;
                mExp[ch] = 0;
            end
        end else begin
            sinceReset++;
            for (int ch = 0; ch < N_CH; ch++) begin
                lv = loadOf(ch);
                mExp[ch] = 0;
                if (start[ch]) begin
                    mCnt[ch] = lv;
                    mRun[ch] = (lv != 0);
                    mExp[ch] = (lv == 0);
                end else if (stop[ch]) begin
                    mRun[ch] = 0;
                end else if (mRun[ch] && tk) begin
                    if (mCnt[ch] > 1) begin
                        mCnt[ch] = mCnt[ch] - 1;
                    end else begin
                        mExp[ch] = 1;
                        if (auto_reload[ch] && lv != 0) begin
                            mCnt[ch] = lv;
                        end else begin
                            mCnt[ch] = 0;
                            mRun[ch] = 0;
                        end
                    end
                end
            end
        end
        #1;
        cycle++;
        checkOutput();
        for (int ch = 0; ch < N_CH; ch++)
            if (expired[ch] === 1'b1) expQ[ch].push_back(cycle);
    endtask

    // Drive start/stop masks for one cycle, then release them.
    task automatic applyStimulus(input logic [N_CH-1:0] s, input logic [N_CH-1:0] p);
        start = s;
        stop  = p;
        runCycle();
        start = '0;
        stop  = '0;
    endtask

    task automatic setLoad(input int ch, input int val);
        load_value[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    initial begin
        int e0;
        int n;
        bit found;
        logic [N_CH-1:0] rs, rp;

        reset       = 1'b1;
        start       = '0;
        stop        = '0;
        auto_reload = '0;
        load_value  = '0;

        // Reset held for five cycles: every output must be zero.
        repeat (5) runCycle();
        checkVal("reset_outputs", {count_out, running, expired, tick}, '0);
        reset = 1'b0;

        // Tick cadence after release.
        n = 0;
        for (int i = 0; i < 40; i++) begin
            runCycle();
            if (tick === 1'b1) n++;
        end
        checkVal("tick_count_40", VW'(n), VW'(4));

        // One-shot channel 0, load 5: expiry 41..50 cycles after start.
        setLoad(0, 5);
        auto_reload[0] = 1'b0;
        applyStimulus(4'b0001, 4'b0000);
        e0 = cycle;
        expQ[0].delete();
        for (int i = 0; i < 60 && expQ[0].size() == 0; i++) runCycle();
        n = (expQ[0].size() > 0) ? expQ[0][0] - e0 : -1;
        checkVal("ch0_expiry_window", VW'((n >= 41 && n <= 50) ? 1 : 0), VW'(1));
        runCycle();
        checkVal("ch0_idle_after", VW'(running[0]), VW'(0));
        checkVal("ch0_count_zero", VW'(count_out[0 +: CNT_W]), VW'(0));
        checkVal("ch0_single_pulse", VW'(expQ[0].size()), VW'(1));

        // Periodic channel 1, load 3: 30 cycles between expiries.
        setLoad(1, 3);
        auto_reload[1] = 1'b1;
        applyStimulus(4'b0010, 4'b0000);
        expQ[1].delete();
        repeat (100) runCycle();
        checkVal("ch1_pulses", VW'(expQ[1].size() >= 3 ? 1 : 0), VW'(1));
        if (expQ[1].size() >= 3) begin
            checkVal("ch1_period_a", VW'(expQ[1][1] - expQ[1][0]), VW'(30));
            checkVal("ch1_period_b", VW'(expQ[1][2] - expQ[1][1]), VW'(30));
        end
        auto_reload[1] = 1'b0;
        expQ[1].delete();
        repeat (80) runCycle();
        checkVal("ch1_last_pulse", VW'(expQ[1].size()), VW'(1));
        checkVal("ch1_stopped", VW'(running[1]), VW'(0));

        // Channel 2, load 8: stop after three ticks holds count 5.
        setLoad(2, 8);
        applyStimulus(4'b0100, 4'b0000);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            runCycle();
            found = (mCnt[2] == 5);
        end
        checkVal("ch2_reached_5", VW'(found), VW'(1));
        applyStimulus(4'b0000, 4'b0100);
        expQ[2].delete();
        repeat (100) runCycle();
        checkVal("ch2_held_5", VW'(count_out[2*CNT_W +: CNT_W]), VW'(5));
        checkVal("ch2_no_expiry", VW'(expQ[2].size()), VW'(0));
        checkVal("ch2_paused", VW'(running[2]), VW'(0));
        applyStimulus(4'b0100, 4'b0000);
        checkVal("ch2_reload_8", VW'(count_out[2*CNT_W +: CNT_W]), VW'(8));
        checkVal("ch2_rerun", VW'(running[2]), VW'(1));

        // Channel 3, load 0: immediate expiry, never running.
        setLoad(3, 0);
        applyStimulus(4'b1000, 4'b0000);
        checkVal("ch3_zero_expired", VW'(expired[3]), VW'(1));
        checkVal("ch3_zero_idle", VW'(running[3]), VW'(0));
        runCycle();
        checkVal("ch3_zero_one_pulse", VW'(expired[3]), VW'(0));

        // Start on channel 0's expiry cycle: restart wins, no pulse.
        setLoad(0, 5);
        applyStimulus(4'b0001, 4'b0000);
        found = 0;
        for (int i = 0; i < 70 && !found; i++) begin
            found = mRun[0] && (mCnt[0] == 1) && tickAt(sinceReset);
            if (!found) runCycle();
        end
        checkVal("ch0_expiry_reached", VW'(found), VW'(1));
        setLoad(0, 7);
        applyStimulus(4'b0001, 4'b0000);
        checkVal("ch0_restart_no_pulse", VW'(expired[0]), VW'(0));
        checkVal("ch0_restart_count", VW'(count_out[0 +: CNT_W]), VW'(7));

        // Reset mid-run on every channel.
        for (int ch = 0; ch < N_CH; ch++) setLoad(ch, 9);
        auto_reload = '1;
        applyStimulus('1, '0);
        repeat (25) runCycle();
        reset = 1'b1;
        runCycle();
        reset = 1'b0;
        checkVal("midreset_running", VW'(running), VW'(0));
        checkVal("midreset_count", count_out, VW'(0));
        checkVal("midreset_expired", VW'(expired), VW'(0));
        runCycle();
        checkVal("midreset_no_stray", VW'(expired), VW'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rs = '0;
            rp = '0;
            for (int ch = 0; ch < N_CH; ch++) begin
                rs[ch] = ($urandom_range(0, 39) == 0);
                rp[ch] = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 49) == 0) auto_reload[ch] = 1'($urandom);
                if ($urandom_range(0, 9) == 0)  setLoad(ch, $urandom_range(0, 6));
            end
            reset = ($urandom_range(0, 799) == 0);
            applyStimulus(rs, rp);
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
